// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clk_div_ctrl divider controller.
// State encoding is fixed at 2 bits so it can be observed on debug buses.
package clk_div_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_PEND = 2'd2;

  localparam int CNT_W_DEF        = 26;
  localparam int DEFAULT_HALF_1HZ = 24999999;
  localparam int MIN_HALF_DEF     = 1;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake bundle: new half-period count offered with valid/ready.
// cfg_err is the controller's one-cycle reject pulse for an out-of-range count.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 26
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_half,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_half,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clk_div_core.sv
// Divide counter and toggle register; tc is combinational, clk_out/tick registered.
// load_clr parks the counter at zero with clk_out low; no backpressure.
module clk_div_core #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] half,
  input  logic             run,
  input  logic             load_clr,
  output logic             tc,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic             clk_out_q;
  logic             tick_q;

  assign tc      = run && (cnt_q == half);
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else if (load_clr) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else if (tc) begin
      cnt_q     <= '0;
      clk_out_q <= ~clk_out_q;
      tick_q    <= 1'b1;
    end else if (run) begin
      cnt_q     <= cnt_q + CNT_W'(1);
      tick_q    <= 1'b0;
    end else begin
      tick_q    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop + glitch-free reconfiguration of a clock divider; new counts land only on clk_out falls.
// cfg_ready drops while a shadow count is pending. CLK_DIV_CTRL_PERIOD_CNT_EN adds period_cnt.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_1HZ,
  parameter int MIN_HALF     = MIN_HALF_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  clk_div_ctrl_if.slave       cfg,
  output logic                clk_out,
  output logic                tick,
  output logic                busy
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]         period_cnt
`endif
);

  localparam logic [CNT_W-1:0] DEF_HALF_C = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] MIN_HALF_C = CNT_W'(MIN_HALF);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             busy_q;

  logic tc;
  logic xfer;
  logic bad_half;
  logic fpb;

  assign xfer     = cfg.cfg_valid && ready_q;
  assign bad_half = cfg.cfg_half < MIN_HALF_C;
  assign fpb      = tc && clk_out;

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;
  assign busy          = busy_q;

  clk_div_core #(
    .CNT_W    (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .half     (half_q),
    .run      (state_q != ST_IDLE),
    .load_clr (state_q == ST_IDLE),
    .tc       (tc),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    shadow_d = shadow_q;
    ready_d  = ready_q;
    err_d    = xfer && bad_half;
    case (state_q)
      ST_IDLE: begin
        // Counter is parked, so a new count can take effect immediately.
        if (xfer && !bad_half) half_d = cfg.cfg_half;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (xfer && !bad_half) begin
          shadow_d = cfg.cfg_half;
          ready_d  = 1'b0;
          state_d  = ST_PEND;
        end else if (fpb && !en) begin
          state_d  = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (fpb) begin
          half_d  = shadow_q;
          ready_d = 1'b1;
          state_d = en ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      half_q   <= DEF_HALF_C;
      shadow_q <= '0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] period_cnt_q;

  assign period_cnt = period_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_q <= '0;
    end else if (state_q == ST_IDLE && state_d == ST_RUN) begin
      period_cnt_q <= '0;
    end else if (fpb && period_cnt_q != 16'hFFFF) begin
      period_cnt_q <= period_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with DEFAULT_HALF=3 (8-cycle period) and hand-derived cycle tables.
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;
  logic en;
  logic clk_out;
  logic tick;
  logic busy;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  int n_vec;
  int n_err;

  clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

  clk_div_ctrl #(
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (3),
    .MIN_HALF     (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg        (cfg_if),
    .clk_out    (clk_out),
    .tick       (tick),
    .busy       (busy)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_vec({tag, ".clk_out"}, 32'(clk_out), 32'd0);
    check_vec({tag, ".tick"}, 32'(tick), 32'd0);
    check_vec({tag, ".busy"}, 32'(busy), 32'd0);
    check_vec({tag, ".cfg_ready"}, 32'(cfg_if.cfg_ready), 32'd1);
    check_vec({tag, ".cfg_err"}, 32'(cfg_if.cfg_err), 32'd0);
  endtask

  initial begin
    bit e_tick, e_clk, e_rdy, e_err, e_busy;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    en = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_half = '0;

    // Power-on reset.
    #2 rst_n = 1'b0;
    #10;
    check_idle_outputs("por");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle_outputs($sformatf("static%0d", i));
    end

    // Async reset mid-count: run until clk_out is high, then pull rst_n between edges.
    en = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check_vec("pre_rst.clk_out", 32'(clk_out), 32'd1);
    check_vec("pre_rst.busy", 32'(busy), 32'd1);
    en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle_outputs($sformatf("post_rst%0d", i));
    end

    // Main sequence, cycle 0 = en raised. Period 8 (rise 5,13,21; fall 9,17,25).
    // c14: reject cfg_half=0 -> err at 15. c18 (clk_out=0,cnt=1): cfg_half=1 -> PEND 19..24,
    // applies at fall 25, then period 4. c35: en=0 while high -> stop at 37. c40: restart,
    // c43/c44: en glitch before FPB must not stop it. c50: cfg_half=2 offered -> PEND at 51.
    en = 1'b1;
    step();
    for (int c = 1; c <= 50; c++) begin
      case (c)
        14: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_half = 8'd0; end
        15: cfg_if.cfg_valid = 1'b0;
        18: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_half = 8'd1; end
        19: cfg_if.cfg_valid = 1'b0;
        35: en = 1'b0;
        40: en = 1'b1;
        43: en = 1'b0;
        44: en = 1'b1;
        50: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_half = 8'd2; end
        default: ;
      endcase
      e_tick = c inside {5, 9, 13, 17, 21, 25, 27, 29, 31, 33, 35, 37, 43, 45, 47, 49};
      e_clk  = c inside {[5:8], [13:16], [21:24], [27:28], [31:32], [35:36], [43:44], [47:48]};
      e_rdy  = !(c inside {[19:24]});
      e_err  = (c == 15);
      e_busy = !(c inside {[37:40]});
      check_vec($sformatf("tick@%0d", c), 32'(tick), 32'(e_tick));
      check_vec($sformatf("clk_out@%0d", c), 32'(clk_out), 32'(e_clk));
      check_vec($sformatf("cfg_ready@%0d", c), 32'(cfg_if.cfg_ready), 32'(e_rdy));
      check_vec($sformatf("cfg_err@%0d", c), 32'(cfg_if.cfg_err), 32'(e_err));
      check_vec($sformatf("busy@%0d", c), 32'(busy), 32'(e_busy));
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
      if (c == 9 || c == 33)
        check_vec($sformatf("period_cnt@%0d", c), 32'(period_cnt), (c == 9) ? 32'd1 : 32'd5);
`endif
      step();
    end

    // Cycle 51: pending reconfiguration, then reset discards it.
    cfg_if.cfg_valid = 1'b0;
    check_vec("pend.cfg_ready", 32'(cfg_if.cfg_ready), 32'd0);
    check_vec("pend.busy", 32'(busy), 32'd1);
    en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_idle_outputs("pend_rst");
    #2 rst_n = 1'b1;
    step();
    check_idle_outputs("pend_rst_rel");

    // Half-period must be back to 3: ticks at 5, 9, 13 after en.
    en = 1'b1;
    step();
    for (int r = 1; r <= 13; r++) begin
      e_tick = r inside {5, 9, 13};
      e_clk  = r inside {[5:8], 13};
      check_vec($sformatf("rerun.tick@%0d", r), 32'(tick), 32'(e_tick));
      check_vec($sformatf("rerun.clk_out@%0d", r), 32'(clk_out), 32'(e_clk));
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
      if (r == 1 || r == 9)
        check_vec($sformatf("rerun.period_cnt@%0d", r), 32'(period_cnt), (r == 1) ? 32'd0 : 32'd1);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run/stop and reconfiguration controller for a programmable clock divider.
- Owns one divide counter and its toggle output.
- Accepts new half-period terminal counts over a valid/ready handshake and applies them only at full-period boundaries, so clk_out never has a runt pulse.
- Stops gracefully on en deassert.
- Sits between the system clock domain and slow-tick consumers: display scan, 1 Hz timebase, blink logic.

Parameters:
- CNT_W, 26, width of the counter and of cfg_half.
- DEFAULT_HALF, 24999999, half-period terminal count after reset (50 MHz in gives 1 Hz out).
- MIN_HALF, 1, smallest accepted cfg_half; smaller values are rejected.

Ports:
- clk  input  1  system clock; everything is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  level run request.
- cfg_valid  input  1  new half-period count offered.
- cfg_half  input  CNT_W  new half-period terminal count.
- cfg_ready  output  1  controller can accept cfg.
- cfg_err  output  1  one-cycle pulse: offered cfg_half < MIN_HALF, rejected.
- clk_out  output  1  divided clock, 50% duty.
- tick  output  1  one-cycle pulse on every clk_out toggle.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE, cnt=0, half_reg=DEFAULT_HALF, shadow=0.
  - clk_out=0, tick=0, cfg_ready=1, cfg_err=0, busy=0.
  - Any pending shadow is discarded.
- All outputs are registered. A cfg transfer occurs on a clock edge with cfg_valid & cfg_ready.
- Terminal count TC = (cnt == half_reg) in RUN or PEND. At TC:
  - cnt <= 0, clk_out <= ~clk_out, tick <= 1 for one cycle.
  - Otherwise cnt <= cnt+1 and tick <= 0.
  - cnt never exceeds half_reg, so no wrap is possible.
- Full-period boundary (FPB) = TC while clk_out == 1, i.e. clk_out falls.
- IDLE:
  - cnt=0, clk_out=0.
  - A cfg transfer loads half_reg directly; state stays IDLE.
  - en=1 -> RUN on the next edge with cnt=0. The first tick/rise occurs half_reg+1 cycles after RUN entry.
- RUN:
  - Counts as above.
  - A cfg transfer latches cfg_half into shadow, cfg_ready <= 0, state -> PEND.
  - en=0 -> keep counting; at the next FPB go to IDLE. That final falling toggle and tick still occur.
  - en reasserted before the FPB -> the stop is cancelled and counting continues uninterrupted.
- PEND:
  - Counts with the old half_reg.
  - At the next FPB: half_reg <= shadow, cnt <= 0, cfg_ready <= 1. State -> RUN if en=1, else IDLE.
  - A transfer on the same cycle as a TC/FPB in RUN still goes to PEND. It applies at the following FPB, never the current one.
- Rejection:
  - cfg_half < MIN_HALF completes the handshake, because cfg_ready was 1.
  - cfg_err pulses high for one cycle; half_reg, shadow and state are unchanged.
- busy = (state != IDLE), registered.
- cfg_ready is 0 only in PEND.

Optional Feature:
- CLK_DIV_CTRL_PERIOD_CNT_EN defined adds output period_cnt [15:0].
  - Counts completed full periods (FPBs) and saturates at 16'hFFFF.
  - Cleared to 0 by reset and on each IDLE->RUN transition.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package clk_div_pkg holds:
  - state typedef (IDLE, RUN, PEND; 2-bit encoding).
  - DEFAULT_HALF_1HZ constant.
  - MIN_HALF default.
- Sub-module clk_div_core: counter plus toggle register, with inputs half, run, load_clr and outputs tc, clk_out, tick.
- clk_div_ctrl holds the FSM, the shadow register and the handshake logic, and instantiates clk_div_core.

Test Plan (DEFAULT_HALF=3 override unless noted):
- Reset: rst_n=0 mid-count -> clk_out=0, tick=0, busy=0, cfg_ready=1, cfg_err=0 immediately (async). After release, en=0 keeps all outputs static.
- Run: en=1 at cycle 0 -> busy=1 at cycle 1; clk_out rises at cycle 5, falls at 9, rises at 13. tick=1 at exactly cycles 5, 9, 13.
- Reconfigure mid-run: cfg_half=1 with clk_out=0, cnt=1 -> cfg_ready=0. The old 8-cycle period completes to the FPB, then the period is 4 cycles; cfg_ready=1 the cycle after the FPB.
- Reject: cfg_half=0 offered in RUN -> cfg_err high exactly 1 cycle, cfg_ready stays 1, period stays 8 cycles.
- Graceful stop: en=0 while clk_out=1 -> counting continues to the falling toggle, then busy=0, clk_out=0, cnt=0. en=0 then re-1 before the FPB -> no gap in tick spacing.
- Reset mid-PEND: cfg_half=1 accepted, then rst_n pulsed -> half_reg back to 3, cfg_ready=1. The next run has an 8-cycle period; with CLK_DIV_CTRL_PERIOD_CNT_EN, period_cnt=0.
